dm_stats_collector: RTL

DM_STATS_COLLECTOR -- requirements
Module: dm_stats_collector

---
 rtl/dm_stats_pkg.sv | 36 +++
 rtl/dm_stream_stats.sv | 85 ++++++++
 rtl/dm_stats_collector.sv | 112 +++++++++++
 3 files changed

// File: rtl/dm_stats_pkg.sv
// rtl/dm_stats_pkg.sv - shared widths, status bit positions and counter helpers
// DM_STATS_SATURATE_EN selects saturating counters instead of wrapping ones.
package dm_stats_pkg;

  localparam int BTT_WIDTH_DEF = 23;
  localparam int LEN_WIDTH_DEF = 48;
  localparam int CNT_WIDTH     = 32;

  localparam int STS_OKAY_BIT = 7;
  localparam int STS_ERR_MSB  = 6;
  localparam int STS_ERR_LSB  = 4;

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  typedef struct packed {
    cnt_t cmd;
    cnt_t word;
    cnt_t pkg;
    cnt_t sts;
    cnt_t sts_err;
  } dir_cnt_t;

  function automatic cnt_t cnt_inc(input cnt_t v);
`ifdef DM_STATS_SATURATE_EN
    return (&v) ? v : v + cnt_t'(1);
`else
    return v + cnt_t'(1);
`endif
  endfunction

  // A status word is bad when OKAY is clear or any of SLVERR/DECERR/INTERR is set.
  function automatic logic sts_is_error(input logic [7:0] sts);
    return !sts[STS_OKAY_BIT] || (|sts[STS_ERR_MSB:STS_ERR_LSB]);
  endfunction

endpackage

// File: rtl/dm_stream_stats.sv
// rtl/dm_stream_stats.sv - event counters for one datamover direction
// DM_STATS_SATURATE_EN makes the length accumulator and counters saturate.
module dm_stream_stats
  import dm_stats_pkg::*;
#(
  parameter int BTT_WIDTH = BTT_WIDTH_DEF,
  parameter int LEN_WIDTH = LEN_WIDTH_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clear,
  input  logic                 i_cmd_valid,
  input  logic                 i_cmd_ready,
  input  logic [BTT_WIDTH-1:0] i_cmd_btt,
  input  logic                 i_data_valid,
  input  logic                 i_data_ready,
  input  logic                 i_data_last,
  input  logic                 i_sts_valid,
  input  logic                 i_sts_ready,
  input  logic [7:0]           i_sts_data,
  input  logic                 i_err_in,
  output dir_cnt_t             o_cnt,
  output logic [LEN_WIDTH-1:0] o_length,
  output logic                 o_error
);

  dir_cnt_t             r_cnt;
  logic [LEN_WIDTH-1:0] r_len;
  logic                 r_error;

  logic                 w_cmd_evt;
  logic                 w_data_evt;
  logic                 w_sts_evt;
  logic [LEN_WIDTH-1:0] w_len_next;

  assign w_cmd_evt  = i_cmd_valid  & i_cmd_ready;
  assign w_data_evt = i_data_valid & i_data_ready;
  assign w_sts_evt  = i_sts_valid  & i_sts_ready;

`ifdef DM_STATS_SATURATE_EN
  logic [LEN_WIDTH:0] w_len_sum;
  assign w_len_sum  = {1'b0, r_len} + (LEN_WIDTH+1)'(i_cmd_btt);
  assign w_len_next = w_len_sum[LEN_WIDTH] ? '1 : w_len_sum[LEN_WIDTH-1:0];
`else
  assign w_len_next = r_len + (LEN_WIDTH)'(i_cmd_btt);
`endif

  // Clear has priority over every same-cycle event; those events are dropped.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_len   <= '0;
      r_error <= 1'b0;
    end else if (i_clear) begin
      r_cnt   <= '0;
      r_len   <= '0;
      r_error <= 1'b0;
    end else begin
      if (w_cmd_evt) begin
        r_cnt.cmd <= cnt_inc(r_cnt.cmd);
        r_len     <= w_len_next;
      end
      if (w_data_evt) begin
        r_cnt.word <= cnt_inc(r_cnt.word);
        if (i_data_last) begin
          r_cnt.pkg <= cnt_inc(r_cnt.pkg);
        end
      end
      if (w_sts_evt) begin
        r_cnt.sts <= cnt_inc(r_cnt.sts);
        if (sts_is_error(i_sts_data)) begin
          r_cnt.sts_err <= cnt_inc(r_cnt.sts_err);
        end
      end
      if (i_err_in) begin
        r_error <= 1'b1;
      end
    end
  end

  assign o_cnt    = r_cnt;
  assign o_length = r_len;
  assign o_error  = r_error;

endmodule

// File: rtl/dm_stats_collector.sv
// rtl/dm_stats_collector.sv - passive statistics tap on both datamover directions
// DM_STATS_SATURATE_EN (in dm_stream_stats/dm_stats_pkg) selects saturating counters.
module dm_stats_collector
  import dm_stats_pkg::*;
#(
  parameter int BTT_WIDTH = BTT_WIDTH_DEF,
  parameter int LEN_WIDTH = LEN_WIDTH_DEF
) (
  input  logic                 mem_clk,
  input  logic                 mem_aresetn,
  input  logic                 stats_clear,

  input  logic                 s2mm_cmd_valid,
  input  logic                 s2mm_cmd_ready,
  input  logic [BTT_WIDTH-1:0] s2mm_cmd_btt,
  input  logic                 s2mm_data_valid,
  input  logic                 s2mm_data_ready,
  input  logic                 s2mm_data_last,
  input  logic                 s2mm_sts_valid,
  input  logic                 s2mm_sts_ready,
  input  logic [7:0]           s2mm_sts_data,
  input  logic                 s2mm_err_in,

  input  logic                 mm2s_cmd_valid,
  input  logic                 mm2s_cmd_ready,
  input  logic [BTT_WIDTH-1:0] mm2s_cmd_btt,
  input  logic                 mm2s_data_valid,
  input  logic                 mm2s_data_ready,
  input  logic                 mm2s_data_last,
  input  logic                 mm2s_sts_valid,
  input  logic                 mm2s_sts_ready,
  input  logic [7:0]           mm2s_sts_data,
  input  logic                 mm2s_err_in,

  output logic [31:0]          write_cmd_counter,
  output logic [31:0]          write_word_counter,
  output logic [31:0]          write_pkg_counter,
  output logic [31:0]          write_sts_counter,
  output logic [31:0]          write_sts_error_counter,
  output logic [LEN_WIDTH-1:0] write_length_counter,

  output logic [31:0]          read_cmd_counter,
  output logic [31:0]          read_word_counter,
  output logic [31:0]          read_pkg_counter,
  output logic [31:0]          read_sts_counter,
  output logic [31:0]          read_sts_error_counter,
  output logic [LEN_WIDTH-1:0] read_length_counter,

  output logic                 s2mm_error,
  output logic                 mm2s_error
);

  dir_cnt_t w_wr_cnt;
  dir_cnt_t w_rd_cnt;

  dm_stream_stats #(
    .BTT_WIDTH (BTT_WIDTH),
    .LEN_WIDTH (LEN_WIDTH)
  ) u_s2mm_stats (
    .i_clk        (mem_clk),
    .i_rst_n      (mem_aresetn),
    .i_clear      (stats_clear),
    .i_cmd_valid  (s2mm_cmd_valid),
    .i_cmd_ready  (s2mm_cmd_ready),
    .i_cmd_btt    (s2mm_cmd_btt),
    .i_data_valid (s2mm_data_valid),
    .i_data_ready (s2mm_data_ready),
    .i_data_last  (s2mm_data_last),
    .i_sts_valid  (s2mm_sts_valid),
    .i_sts_ready  (s2mm_sts_ready),
    .i_sts_data   (s2mm_sts_data),
    .i_err_in     (s2mm_err_in),
    .o_cnt        (w_wr_cnt),
    .o_length     (write_length_counter),
    .o_error      (s2mm_error)
  );

  dm_stream_stats #(
    .BTT_WIDTH (BTT_WIDTH),
    .LEN_WIDTH (LEN_WIDTH)
  ) u_mm2s_stats (
    .i_clk        (mem_clk),
    .i_rst_n      (mem_aresetn),
    .i_clear      (stats_clear),
    .i_cmd_valid  (mm2s_cmd_valid),
    .i_cmd_ready  (mm2s_cmd_ready),
    .i_cmd_btt    (mm2s_cmd_btt),
    .i_data_valid (mm2s_data_valid),
    .i_data_ready (mm2s_data_ready),
    .i_data_last  (mm2s_data_last),
    .i_sts_valid  (mm2s_sts_valid),
    .i_sts_ready  (mm2s_sts_ready),
    .i_sts_data   (mm2s_sts_data),
    .i_err_in     (mm2s_err_in),
    .o_cnt        (w_rd_cnt),
    .o_length     (read_length_counter),
    .o_error      (mm2s_error)
  );

  assign write_cmd_counter       = w_wr_cnt.cmd;
  assign write_word_counter      = w_wr_cnt.word;
  assign write_pkg_counter       = w_wr_cnt.pkg;
  assign write_sts_counter       = w_wr_cnt.sts;
  assign write_sts_error_counter = w_wr_cnt.sts_err;

  assign read_cmd_counter        = w_rd_cnt.cmd;
  assign read_word_counter       = w_rd_cnt.word;
  assign read_pkg_counter        = w_rd_cnt.pkg;
  assign read_sts_counter        = w_rd_cnt.sts;
  assign read_sts_error_counter  = w_rd_cnt.sts_err;

endmodule
